dma_multichannel: RTL and testbench

Parametrised N-channel DMA controller; successor to the fixed two-device DMA engine. Each channel holds a source/destination/count descriptor, is triggered by its device request line, and moves words memory↔IO over the shared processor bus after a busreq/grant handshake. Sits beside the processor behind the existing bus muxes; its busreq drives the mux select and the processor's grant.

---
 rtl/dma_pkg.sv | 10 +
 rtl/dma_rr_arbiter.sv | 29 ++
 rtl/dma_multichannel.sv | 114 +++++++++++
 tb/tb_dma_multichannel.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM state type and processor-bus address map for the DMA controller.
package dma_pkg;
    typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, DONE} state_t;
    localparam int MEM_BASE = 0;
    localparam int MEM_TOP  = 191;
    localparam int IO1_BASE = 192;
    localparam int IO1_TOP  = 223;
    localparam int IO2_BASE = 224;
    localparam int IO2_TOP  = 255;
endpackage

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: picks one requesting channel; round-robin from ptr with DMA_ROUND_ROBIN_EN,
// lowest index wins otherwise.
module dma_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
`ifdef DMA_ROUND_ROBIN_EN
    input  logic [IW-1:0] ptr,
`endif
    input  logic [N-1:0]  request,
    output logic [IW-1:0] index,
    output logic          any
);
    logic [IW-1:0] c;
    always_comb begin
        index = '0;
        c = '0;
        any = |request;
        // scan from the far end so the highest-priority requester is written last
        for (int i = N - 1; i >= 0; i--) begin
`ifdef DMA_ROUND_ROBIN_EN
            c = IW'((int'(ptr) + i) % N);
`else
            c = IW'(i);
`endif
            if (request[c]) index = c;
        end
    end
endmodule

// File: rtl/dma_multichannel.sv
// dma_multichannel: N-channel memory<->IO DMA sharing the processor bus via busreq/grant.
// Define DMA_ROUND_ROBIN_EN for round-robin channel arbitration; fixed lowest-index priority otherwise.
module dma_multichannel
    import dma_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int CW = 6,
    localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [IW-1:0]       cfg_ch,
    input  logic [AW-1:0]       cfg_src,
    input  logic [AW-1:0]       cfg_dst,
    input  logic [CW-1:0]       cfg_count,
    input  logic [CHANNELS-1:0] req,
    output logic                busreq,
    input  logic                grant,
    output logic [AW-1:0]       bus_addr,
    output logic                bus_rd,
    output logic                bus_wr,
    output logic [DW-1:0]       bus_wdata,
    input  logic [DW-1:0]       bus_rdata,
    output logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] busy
);
    state_t state, nxt;
    logic [IW-1:0] cur, win;
    logic win_any, cfg_ok;
    logic [AW-1:0] src [CHANNELS];
    logic [AW-1:0] dst [CHANNELS];
    logic [CW-1:0] cnt [CHANNELS];
    logic [AW-1:0] addr_q;
    logic [DW-1:0] hold;
`ifdef DMA_ROUND_ROBIN_EN
    logic [IW-1:0] ptr;
`endif

    dma_rr_arbiter #(.N(CHANNELS), .IW(IW)) u_arb (
`ifdef DMA_ROUND_ROBIN_EN
        .ptr(ptr),
`endif
        .request(busy & req),
        .index(win),
        .any(win_any)
    );

    always_comb begin
        busy = '0;
        for (int c = 0; c < CHANNELS; c++) busy[c] = cnt[c] != '0;
    end

    // the channel being serviced cannot be reprogrammed until the FSM returns to IDLE
    assign cfg_ok    = cfg_we && (state == IDLE || cfg_ch != cur);
    assign busreq    = state == REQ || state == READ || state == WRITE;
    assign bus_rd    = state == READ;
    assign bus_wr    = state == WRITE;
    assign bus_addr  = bus_rd ? src[cur] : bus_wr ? dst[cur] : addr_q;
    assign bus_wdata = hold;
    assign ack       = state == DONE ? CHANNELS'(1) << cur : '0;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = win_any ? REQ : IDLE;
            REQ:     nxt = grant ? READ : REQ;
            READ:    nxt = WRITE;
            WRITE:   nxt = cnt[cur] == CW'(1) ? DONE : grant ? READ : REQ;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur <= '0;
            addr_q <= '0;
            hold <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                src[c] <= '0;
                dst[c] <= '0;
                cnt[c] <= '0;
            end
`ifdef DMA_ROUND_ROBIN_EN
            ptr <= '0;
`endif
        end else begin
            if (state == IDLE) cur <= win;
            if (bus_rd || bus_wr) addr_q <= bus_addr;
            if (bus_rd) hold <= bus_rdata;
            if (cfg_ok) begin
                src[cfg_ch] <= cfg_src;
                dst[cfg_ch] <= cfg_dst;
                cnt[cfg_ch] <= cfg_count;
            end
            if (bus_wr) begin
                cnt[cur] <= cnt[cur] - CW'(1);
                src[cur] <= src[cur] + AW'(1);
                dst[cur] <= dst[cur] + AW'(1);
            end
`ifdef DMA_ROUND_ROBIN_EN
            if (state == DONE) ptr <= int'(cur) == CHANNELS - 1 ? '0 : cur + IW'(1);
`endif
        end
    end
endmodule

// File: tb/tb_dma_multichannel.sv
// tb_dma_multichannel: scoreboard bench; bus reads, writes and acks are predicted when bursts are armed
// and checked by a monitor as the DUT drives the bus.
module tb_dma_multichannel;
    localparam int CH = 2, AW = 8, DW = 32, CW = 6;
    logic clock = 0, reset = 1, cfg_we = 0, grant = 1;
    logic [0:0] cfg_ch = '0;
    logic [AW-1:0] cfg_src = '0, cfg_dst = '0;
    logic [CW-1:0] cfg_count = '0;
    logic [CH-1:0] req = '0, ack, busy;
    logic busreq, bus_rd, bus_wr;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    int errors = 0, checks = 0, cyc = 0;
    logic [AW-1:0] rd_q[$];
    logic [AW+DW-1:0] wr_q[$];
    int ack_q[$];

    dma_multichannel #(.CHANNELS(CH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_count(cfg_count), .req(req),
        .busreq(busreq), .grant(grant), .bus_addr(bus_addr), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .ack(ack), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return {~a, 8'h3C, a ^ 8'h5A, a};
    endfunction
    assign bus_rdata = mem_val(bus_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (bus_rd || bus_wr) check("rd_wr_exclusive", 64'(bus_rd && bus_wr), 64'd0);
        if (bus_rd) begin
            check("rd_pending", 64'(rd_q.size() != 0), 64'd1);
            if (rd_q.size() != 0) check("rd_addr", 64'(bus_addr), 64'(rd_q.pop_front()));
        end
        if (bus_wr) begin
            check("wr_pending", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) check("wr_addr_data", 64'({bus_addr, bus_wdata}), 64'(wr_q.pop_front()));
        end
        if (ack != '0) begin
            check("ack_pending", 64'(ack_q.size() != 0), 64'd1);
            if (ack_q.size() != 0) check("ack_ch", 64'(ack), 64'd1 << ack_q.pop_front());
        end
    end

    task automatic cyc_wait();
        @(posedge clock);
        #2;
    endtask

    task automatic arm(input int ch, input int s, input int d, input int n);
        @(negedge clock);
        cfg_we = 1;
        cfg_ch = 1'(ch);
        cfg_src = AW'(s);
        cfg_dst = AW'(d);
        cfg_count = CW'(n);
        @(negedge clock);
        cfg_we = 0;
    endtask

    task automatic expect_burst(input int ch, input int s, input int d, input int n);
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(AW'(s + i));
            wr_q.push_back({AW'(d + i), mem_val(AW'(s + i))});
        end
        ack_q.push_back(ch);
    endtask

    task automatic wait_ack(input int ch, output int at, output logic pb);
        logic last;
        at = -1;
        pb = 0;
        last = 0;
        for (int i = 0; i < 100 && at < 0; i++) begin
            cyc_wait();
            if (ack != '0) begin
                at = cyc;
                pb = last;
            end
            last = busy[ch];
        end
        check("ack_seen", 64'(at >= 0), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0 || ack_q.size() != 0 || busreq) && n < 300) begin
            cyc_wait();
            n++;
        end
        check("drained", 64'(rd_q.size() + wr_q.size() + ack_q.size()), 64'd0);
    endtask

    initial begin
        int g, at;
        logic pb;
        repeat (2) @(negedge clock);
        check("rst_busreq", 64'(busreq), 64'd0);
        check("rst_rd_wr", 64'({bus_rd, bus_wr}), 64'd0);
        check("rst_ack_busy", 64'({ack, busy}), 64'd0);
        check("rst_addr_wdata", 64'({bus_addr, bus_wdata}), 64'd0);
        reset = 0;

        // basic 3-word burst with grant tied high
        arm(0, 10, 200, 3);
        expect_burst(0, 10, 200, 3);
        check("arm_busy0", 64'(busy), 64'd1);
        req = 2'b01;
        cyc_wait();
        check("busreq_t1", 64'(busreq), 64'd1);
        g = cyc;
        wait_ack(0, at, pb);
        check("ack_latency3", 64'(at - g), 64'd7);
        check("ack_busreq_low", 64'(busreq), 64'd0);
        drain();
        @(negedge clock) req = 2'b00;

        // address wrap on channel 1
        arm(1, 254, 0, 3);
        expect_burst(1, 254, 0, 3);
        req = 2'b10;
        wait_ack(1, at, pb);
        check("wrap_busy_before", 64'(pb), 64'd1);
        check("wrap_busy_at_ack", 64'(busy[1]), 64'd0);
        drain();
        @(negedge clock) req = 2'b00;

        // grant withdrawn during the second word of a 4-word burst
        arm(0, 40, 100, 4);
        expect_burst(0, 40, 100, 4);
        req = 2'b01;
        cyc_wait();
        g = cyc;
        check("gd_busreq", 64'(busreq), 64'd1);
        repeat (3) cyc_wait();
        check("gd_read2", 64'(bus_rd), 64'd1);
        @(negedge clock) grant = 0;
        cyc_wait();
        check("gd_write2", 64'(bus_wr), 64'd1);
        repeat (5) begin
            cyc_wait();
            check("gd_hold_busreq", 64'(busreq), 64'd1);
            check("gd_hold_bus_idle", 64'({bus_rd, bus_wr}), 64'd0);
        end
        @(negedge clock) grant = 1;
        wait_ack(0, at, pb);
        check("gd_ack_latency", 64'(at - g), 64'd14);
        drain();
        @(negedge clock) req = 2'b00;

        // arbitration: fresh pointer, then ch0 alone, then both competing
        @(negedge clock) reset = 1;
        @(negedge clock) reset = 0;
        arm(0, 60, 120, 2);
        arm(1, 70, 130, 2);
        expect_burst(0, 60, 120, 2);
        expect_burst(1, 70, 130, 2);
        req = 2'b11;
        drain();
        arm(0, 80, 140, 2);
        expect_burst(0, 80, 140, 2);
        drain();
        @(negedge clock) req = 2'b00;
        arm(0, 90, 150, 2);
        arm(1, 95, 160, 2);
`ifdef DMA_ROUND_ROBIN_EN
        expect_burst(1, 95, 160, 2);
        expect_burst(0, 90, 150, 2);
`else
        expect_burst(0, 90, 150, 2);
        expect_burst(1, 95, 160, 2);
`endif
        req = 2'b11;
        drain();
        @(negedge clock) req = 2'b00;

        // reprogramming the active channel mid-burst is ignored
        arm(0, 150, 210, 4);
        expect_burst(0, 150, 210, 4);
        req = 2'b01;
        repeat (3) cyc_wait();
        arm(0, 0, 0, 9);
        drain();
        check("cfg_ignored_busy", 64'(busy), 64'd0);
        repeat (5) cyc_wait();
        check("cfg_ignored_quiet", 64'(busreq), 64'd0);
        @(negedge clock) req = 2'b00;

        // count 0 disarms an idle channel
        arm(1, 33, 44, 5);
        check("arm1_busy", 64'(busy), 64'd2);
        arm(1, 33, 44, 0);
        check("disarm_busy", 64'(busy), 64'd0);
        req = 2'b10;
        repeat (4) cyc_wait();
        check("disarm_no_busreq", 64'(busreq), 64'd0);
        @(negedge clock) req = 2'b00;

        // reset during READ aborts the burst with no ack
        arm(0, 5, 6, 3);
        rd_q.push_back(AW'(5));
        req = 2'b01;
        for (int i = 0; i < 20 && !bus_rd; i++) cyc_wait();
        check("rst_saw_read", 64'(bus_rd), 64'd1);
        @(negedge clock) reset = 1;
        cyc_wait();
        check("rst_mid_busreq", 64'(busreq), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_ack", 64'(ack), 64'd0);
        @(negedge clock) reset = 0;
        repeat (5) begin
            cyc_wait();
            check("rst_no_ack", 64'(ack), 64'd0);
        end
        check("rst_desc_lost", 64'(busreq), 64'd0);
        check("rst_queues", 64'(rd_q.size() + wr_q.size() + ack_q.size()), 64'd0);
        req = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
